// File: rtl/forth_core_p.sv
// Dual-stack Forth CPU, one shared req/ready memory port, single clock; OFFSET_REG_EN adds a base-offset register.
// Latency: fetch accept -> EXEC -> next fetch request (2 cycles); memory ops add one request/accept round trip.
// Backpressure: request fields are held until mem_ready; mem_req drops the cycle after acceptance.
module forth_core_p #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int PSTACK_DEPTH = 16,
  parameter int RSTACK_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       ins,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              stack_fault
);
  localparam int PW = $clog2(PSTACK_DEPTH + 1);
  localparam int RW = $clog2(RSTACK_DEPTH + 1);
  localparam int PI = $clog2(PSTACK_DEPTH);
  localparam int RI = (RSTACK_DEPTH > 1) ? $clog2(RSTACK_DEPTH) : 1;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  state_t state;

  logic [DATA_W-1:0] pstk [PSTACK_DEPTH];
  logic [DATA_W-1:0] rstk [RSTACK_DEPTH];
  logic [PW-1:0]     pdepth, pd_nx;
  logic [RW-1:0]     rdepth, rd_nx;
  logic [PI-1:0]     tos_idx, top_idx, sec_idx;
  logic [RI-1:0]     r_idx;
  logic [DATA_W-1:0] tos, nos, rtos;
  logic [ADDR_W-1:0] ofs, ofs_nx, pc_inc, pc_nx;

`ifdef OFFSET_REG_EN
  logic [ADDR_W-1:0] ofs_r;
  assign ofs = ofs_r;
`else
  assign ofs = '0;
`endif

  assign tos_idx = PI'(pdepth - PW'(1));
  assign tos     = pstk[tos_idx];
  assign nos     = pstk[PI'(pdepth - PW'(2))];
  assign rtos    = rstk[RI'(rdepth - RW'(1))];
  assign pc_inc  = pc + ADDR_W'(1);

  int p_need, p_push, r_need, r_push;
  logic fault, is_mem, is_halt, ofs_we, top_we, sec_we, rpush_we;
  logic [DATA_W-1:0] top_val, sec_val, rpush_val, alu_res, shamt;
  logic [3:0] op;

  // Decode the latched instruction: operand needs, stack writes, next pc and fault.
  always_comb begin
    p_need = 0; p_push = 0; r_need = 0; r_push = 0;
    is_mem = 1'b0; is_halt = 1'b0; ofs_we = 1'b0;
    top_we = 1'b0; sec_we = 1'b0; rpush_we = 1'b0;
    top_val = tos; sec_val = nos; rpush_val = '0;
    alu_res = '0; pc_nx = pc_inc;
    op = ins[3:0];
    shamt = DATA_W'(tos % DATA_W);
    if (ins[15]) begin
      p_push = 1; top_we = 1'b1; top_val = DATA_W'(ins[14:0]);
    end else begin
      case (ins[14:12])
        3'd0: begin
          case (op)
            4'd0: alu_res = nos + tos;
            4'd1: alu_res = nos - tos;
            4'd2: alu_res = nos & tos;
            4'd3: alu_res = nos | tos;
            4'd4: alu_res = nos ^ tos;
            4'd5: alu_res = nos << shamt;
            4'd6: alu_res = nos >> shamt;
            4'd7: alu_res = {DATA_W{nos == tos}};
            4'd8: alu_res = {DATA_W{nos < tos}};
            4'd9: alu_res = ~tos;
            default: alu_res = '0;
          endcase
          if (op <= 4'd8) begin
            p_need = 2; p_push = 1; top_we = 1'b1; top_val = alu_res;
          end else if (op == 4'd9) begin
            p_need = 1; p_push = 1; top_we = 1'b1; top_val = alu_res;
          end
        end
        3'd1: begin
          case (op)
            4'd0: begin p_need = 1; p_push = 2; top_we = 1'b1; top_val = tos; end
            4'd1: p_need = 1;
            4'd2: begin
              p_need = 2; p_push = 2;
              top_we = 1'b1; top_val = nos; sec_we = 1'b1; sec_val = tos;
            end
            4'd3: begin p_need = 2; p_push = 3; top_we = 1'b1; top_val = nos; end
            4'd4: begin p_need = 1; r_push = 1; rpush_we = 1'b1; rpush_val = tos; end
            4'd5: begin r_need = 1; p_push = 1; top_we = 1'b1; top_val = rtos; end
`ifdef OFFSET_REG_EN
            4'd6: begin p_need = 1; ofs_we = 1'b1; end
`endif
            default: ;
          endcase
        end
        3'd2: begin
          if (op == 4'd0) begin p_need = 1; p_push = 1; is_mem = 1'b1; end
          else if (op == 4'd1) begin p_need = 2; is_mem = 1'b1; end
        end
        3'd3: begin p_need = 1; pc_nx = tos[ADDR_W-1:0]; end
        3'd4: begin
          p_need = 2;
          if (nos == '0) pc_nx = tos[ADDR_W-1:0];
        end
        3'd5: begin
          p_need = 1; r_push = 1; rpush_we = 1'b1;
          rpush_val = DATA_W'(pc_inc); pc_nx = tos[ADDR_W-1:0];
        end
        3'd6: begin r_need = 1; pc_nx = rtos[ADDR_W-1:0]; end
        default: is_halt = 1'b1;
      endcase
    end
    fault = (int'(pdepth) < p_need) || (int'(pdepth) - p_need + p_push > PSTACK_DEPTH) ||
            (int'(rdepth) < r_need) || (int'(rdepth) - r_need + r_push > RSTACK_DEPTH);
    pd_nx   = PW'(int'(pdepth) - p_need + p_push);
    rd_nx   = RW'(int'(rdepth) - r_need + r_push);
    top_idx = PI'(pd_nx - PW'(1));
    sec_idx = PI'(pd_nx - PW'(2));
    r_idx   = RI'(rd_nx - RW'(1));
    ofs_nx  = ofs_we ? tos[ADDR_W-1:0] : ofs;
  end

  // Fetch/execute/memory sequencer; a faulting instruction changes nothing but the fault/halt flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH; pc <= RESET_PC; ins <= '0;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
      halted <= 1'b0; stack_fault <= 1'b0; pdepth <= '0; rdepth <= '0;
`ifdef OFFSET_REG_EN
      ofs_r <= '0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req <= 1'b1; mem_we <= 1'b0; mem_addr <= pc + ofs;
          end else if (mem_ready) begin
            mem_req <= 1'b0; ins <= mem_rdata[15:0]; state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (fault) begin
            stack_fault <= 1'b1; halted <= 1'b1; state <= S_HALT;
          end else if (is_halt) begin
            halted <= 1'b1; state <= S_HALT;
          end else if (is_mem) begin
            mem_req <= 1'b1; mem_we <= op[0];
            mem_addr <= tos[ADDR_W-1:0] + ofs; mem_wdata <= nos; state <= S_MEM;
          end else begin
            pdepth <= pd_nx; rdepth <= rd_nx;
            if (top_we) pstk[top_idx] <= top_val;
            if (sec_we) pstk[sec_idx] <= sec_val;
            if (rpush_we) rstk[r_idx] <= rpush_val;
`ifdef OFFSET_REG_EN
            ofs_r <= ofs_nx;
`endif
            pc <= pc_nx;
            mem_req <= 1'b1; mem_we <= 1'b0; mem_addr <= pc_nx + ofs_nx;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (mem_we) pdepth <= pdepth - PW'(2);
            else pstk[tos_idx] <= mem_rdata;
            pc <= pc_inc; state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_forth_core_p.sv
// Bench for forth_core_p: directed programs plus randomized ALU programs with random memory stalls,
// checked against a queue-based stack model. A second instance uses a two-entry data stack.
module tb_forth_core_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_req, mem_we, mem_ready, halted, stack_fault;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, ins, pc;
  logic        mem_req2, mem_we2, ready2, halted2, stack_fault2;
  logic [15:0] mem_addr2, mem_wdata2, mem_rdata2, ins2, pc2;

  logic [15:0] mem [0:1023];
  logic [15:0] mem2 [0:15];
  logic ready_man, stall_rand;
  logic rnd_bit = 1'b0;

  assign mem_rdata  = mem[mem_addr[9:0]];
  assign mem_rdata2 = mem2[mem_addr2[3:0]];
  assign mem_ready  = stall_rand ? rnd_bit : ready_man;

  forth_core_p dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ins(ins), .pc(pc), .halted(halted), .stack_fault(stack_fault)
  );

  forth_core_p #(.PSTACK_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_ready(ready2), .mem_rdata(mem_rdata2),
    .ins(ins2), .pc(pc2), .halted(halted2), .stack_fault(stack_fault2)
  );

  localparam logic [15:0] HALT = 16'h7000, STORE = 16'h2001, JZ = 16'h4000;
  localparam logic [15:0] CALL = 16'h5000, RET = 16'h6000, DROP = 16'h1001, SETOFS = 16'h1006;

  function automatic logic [15:0] lit(input int v);
    return 16'h8000 | 16'(v & 32'h7fff);
  endfunction

  // Memory-side observation: writes, read addresses, and requests from the small instance.
  int wr_cnt = 0, rd_cnt = 0, req2_cnt = 0;
  logic [15:0] last_wa = '0, last_wd = '0;
  logic [15:0] rlog [0:63];
  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) begin
      wr_cnt <= wr_cnt + 1; last_wa <= mem_addr; last_wd <= mem_wdata;
    end
    if (rst) rd_cnt <= 0;
    else if (mem_req && mem_ready && !mem_we) begin
      if (rd_cnt < 64) rlog[rd_cnt[5:0]] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (!rst && mem_req2) req2_cnt <= req2_cnt + 1;
  end

  int passed = 0, total = 0, failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = HALT;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int bound);
    for (int n = 0; n < bound && halted !== 1'b1; n++) @(negedge clk);
    check({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  // Reference: literal pushes then one ALU op on a plain queue stack; returns top of stack.
  function automatic logic [15:0] ref_alu(input int opc, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] st[$];
    logic [15:0] t, n, r;
    st.push_back(a);
    st.push_back(b);
    t = st.pop_back();
    if (opc == 9) begin
      st.push_back(~t);
    end else begin
      n = st.pop_back();
      case (opc)
        0: r = n + t;
        1: r = n - t;
        2: r = n & t;
        3: r = n | t;
        4: r = n ^ t;
        5: r = n << (t % 16);
        6: r = n >> (t % 16);
        7: r = (n == t) ? 16'hffff : 16'h0000;
        default: r = (n < t) ? 16'hffff : 16'h0000;
      endcase
      st.push_back(r);
    end
    return st[$];
  endfunction

  initial begin
    int w0, r0, seen, opc;
    logic [15:0] a, b, exp;
    logic stable_ok;
    rst = 1'b1; ready_man = 1'b1; stall_rand = 1'b0; ready2 = 1'b1;
    clear_mem();
    for (int i = 0; i < 16; i++) mem2[i] = HALT;

    // Reset values, then LIT 3, LIT 4, ADD, LIT 0x20, STORE, HALT.
    mem[0] = lit(3); mem[1] = lit(4); mem[2] = 16'h0000;
    mem[3] = lit(16'h20); mem[4] = STORE; mem[5] = HALT;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_ins", 32'(ins), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fault", 32'(stack_fault), 0);
    rst = 1'b0;
    wait_halt("add_store", 200);
    check("add_store_fault", 32'(stack_fault), 0);
    check("add_store_addr", 32'(last_wa), 32'h20);
    check("add_store_data", 32'(last_wd), 7);
    check("add_store_wrcnt", wr_cnt, 1);

    // Fetch stalled for 5 cycles: request held, ins unchanged until the accept.
    clear_mem();
    mem[0] = lit(16'h1234);
    ready_man = 1'b0;
    do_reset();
    stable_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!(mem_req === 1'b1 && mem_addr === 16'h0 && ins === 16'h0)) stable_ok = 1'b0;
    end
    ready_man = 1'b1;
    check("stall_stable", 32'(stable_ok), 1);
    @(negedge clk);
    check("stall_ins", 32'(ins), 32'h9234);
    check("stall_req_drop", 32'(mem_req), 0);
    @(negedge clk);
    check("next_fetch_req", 32'(mem_req), 1);
    check("next_fetch_addr", 32'(mem_addr), 1);

    // JZ with non-zero flag falls through; zero flag jumps.
    clear_mem();
    mem[0] = lit(1); mem[1] = lit(16'h10); mem[2] = JZ;
    do_reset();
    wait_halt("jz_nojump", 200);
    check("jz_nojump_pc", 32'(pc), 3);
    mem[0] = lit(0);
    do_reset();
    wait_halt("jz_jump", 200);
    check("jz_jump_pc", 32'(pc), 32'h10);

    // CALL 0x40, RET returns to call site + 1.
    clear_mem();
    mem[0] = lit(16'h40); mem[1] = CALL; mem[16'h40] = RET;
    do_reset();
    wait_halt("call_ret", 200);
    check("call_ret_pc", 32'(pc), 2);
    check("call_ret_fault", 32'(stack_fault), 0);
    check("call_target_fetch", 32'(rlog[2]), 32'h40);
    check("ret_fetch", 32'(rlog[3]), 2);

    // Two-entry data stack: third LIT overflows, DROP on empty underflows.
    mem2[0] = lit(1); mem2[1] = lit(2); mem2[2] = lit(3);
    do_reset();
    for (int n = 0; n < 100 && halted2 !== 1'b1; n++) @(negedge clk);
    check("ovf_halted", 32'(halted2), 1);
    check("ovf_fault", 32'(stack_fault2), 1);
    check("ovf_pc", 32'(pc2), 2);
    r0 = req2_cnt;
    repeat (10) @(negedge clk);
    check("ovf_no_req", req2_cnt - r0, 0);
    mem2[0] = DROP;
    do_reset();
    for (int n = 0; n < 100 && halted2 !== 1'b1; n++) @(negedge clk);
    check("udf_fault", 32'(stack_fault2), 1);
    check("udf_pc", 32'(pc2), 0);

    // Reset while a STORE is waiting for ready: no write, pc back to reset value.
    clear_mem();
    mem[0] = lit(5); mem[1] = lit(16'h30); mem[2] = STORE;
    do_reset();
    seen = 0;
    for (int n = 0; n < 100 && seen == 0; n++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b1) begin
        ready_man = 1'b0; seen = 1;
      end
    end
    check("store_req_seen", seen, 1);
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_store_req", 32'(mem_req), 0);
    check("rst_store_pc", 32'(pc), 0);
    @(negedge clk);
    check("rst_store_nowrite", wr_cnt - w0, 0);
    ready_man = 1'b1;
    mem[2] = HALT;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Offset register: LIT 0x100, SETOFS, DROP, HALT.
    clear_mem();
    mem[0] = lit(16'h100); mem[1] = SETOFS; mem[2] = DROP;
    do_reset();
    wait_halt("setofs", 200);
    check("setofs_fault", 32'(stack_fault), 0);
`ifdef OFFSET_REG_EN
    check("setofs_fetch_addr", 32'(rlog[2]), 32'h102);
    check("setofs_pc", 32'(pc), 2);
`else
    check("setofs_fetch_addr", 32'(rlog[2]), 2);
    check("setofs_pc", 32'(pc), 3);
`endif

    // Randomized ALU programs under random memory stalls.
    stall_rand = 1'b1;
    for (int it = 0; it < 24; it++) begin
      opc = $urandom_range(0, 9);
      a = 16'($urandom_range(0, 32767));
      b = (it % 4 == 0) ? a : 16'($urandom_range(0, 32767));
      exp = ref_alu(opc, a, b);
      clear_mem();
      mem[0] = lit(a); mem[1] = lit(b); mem[2] = 16'(opc);
      mem[3] = lit(16'h200); mem[4] = STORE;
      w0 = wr_cnt;
      do_reset();
      wait_halt($sformatf("rnd%0d", it), 400);
      check($sformatf("rnd%0d_op%0d_data", it, opc), 32'(last_wd), 32'(exp));
      check($sformatf("rnd%0d_addr", it), 32'(last_wa), 32'h200);
      check($sformatf("rnd%0d_one_write", it), wr_cnt - w0, 1);
    end
    stall_rand = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
